// File: rtl/seg_pkg.sv
// Shared types and constants for the seg_scan_ctrl display scanner.
package seg_pkg;

    // Scan FSM: dark gap between digits, then one digit driven.
    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // One complete display image: four hex nibbles plus their decimal points.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } disp_t;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex to 7-segment decode, active-low, bit 0 = a, bit 6 = g.
module seg_hex_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the lit-segment pattern for each hex digit.
    always_comb begin
        unique case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a shadow/active register
// pair so a new image is only committed at a frame boundary.
// Optional feature: define SEG_BLINK_EN to add the per-digit blink port,
// the frame counter and the blink phase.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
`ifdef SEG_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    // One shared phase counter, wide enough for the longer of the two phases.
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

    // Reject parameter values outside the supported range at elaboration.
    if (SCAN_DIV < 2 || BLANK_CYC < 1 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("seg_scan_ctrl: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    disp_t            active_q, active_d;
    disp_t            shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;

    logic             blank_end;
    logic             drive_end;
    logic [3:0]       cur_nibble;
    logic [6:0]       dec_seg;

    assign blank_end = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
    assign drive_end = (state_q == S_DRIVE) && (cnt_q == DRIVE_LAST);

    // Next-state, digit advance and shadow/active handoff.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        digit_d      = digit_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;

        unique case (state_q)
            S_BLANK: begin
                if (blank_end) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (drive_end) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    if (digit_q == LAST_DIGIT) begin
                        frame_tick_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_BLANK;
        endcase

        // A load lands after any commit so a coincident load stays pending.
        if (load) begin
            shadow_d  = '{value: value, dp: dp};
            pending_d = 1'b1;
        end
    end

    // Decode the nibble that will be shown in the next cycle.
    assign cur_nibble = active_d.value[{digit_d, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             phase_q, phase_d;

    // Count completed frames and flip the blink phase every BLINK_FRAMES.
    always_comb begin
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        if (frame_tick_d) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // Blink phase register; starts in the visible phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            phase_q   <= phase_d;
        end
    end
`endif

    // Output image for the next cycle, so the registers track the FSM.
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        if (state_d == S_DRIVE) begin
            an_d   = ~(4'b0001 << digit_d);
            seg_d  = dec_seg;
            dp_n_d = ~active_d.dp[digit_d];
`ifdef SEG_BLINK_EN
            if (!phase_q && blink[digit_d]) begin
                an_d = AN_OFF;
            end
`endif
        end
    end

    // State, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            digit_q      <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule
